// File: rtl/ones_pkg.sv
// Shared defaults, count type and FIFO occupancy encoding for the ones-count
// result path.
package ones_pkg;

  localparam int W_DEFAULT     = 30;
  localparam int DEPTH_DEFAULT = 4;
  localparam int CW_DEFAULT    = $clog2(W_DEFAULT + 1);

  typedef logic [CW_DEFAULT-1:0] cnt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PART  = 2'd1,
    FULL  = 2'd2
  } occ_t;

  function automatic occ_t occ_of(input int unsigned lvl, input int unsigned depth);
    if (lvl == 0) return EMPTY;
    if (lvl >= depth) return FULL;
    return PART;
  endfunction

endpackage

// File: rtl/ones_fifo_core.sv
// Show-ahead FIFO storage: head/tail pointers, level and a registered head
// read that also covers fall-through of a push into an empty FIFO.
module ones_fifo_core
  import ones_pkg::*;
#(
  parameter int CW    = CW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          push,
  input  logic          pop,
  input  logic [CW-1:0] wdata,
  output logic [CW-1:0] out_data,
  output logic [LW-1:0] level,
  output logic          out_valid,
  output logic          full
);

  logic [CW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_out_data;
  logic [AW-1:0] w_head_nxt;
  occ_t          w_occ;

  always_comb begin
    w_head_nxt = r_head;
    if (pop) w_head_nxt = r_head + 1'b1;
    w_occ = occ_of(32'(r_level), DEPTH);
  end

  always_ff @(posedge clock) begin
    if (push) r_mem[r_tail] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_level    <= '0;
      r_out_data <= '0;
    end else begin
      if (push) r_tail <= r_tail + 1'b1;
      r_head <= w_head_nxt;
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      // New head is the word being written when it lands exactly at the head slot.
      if (push || pop)
        r_out_data <= (push && (r_tail == w_head_nxt)) ? wdata : r_mem[w_head_nxt];
    end
  end

  assign out_data  = r_out_data;
  assign level     = r_level;
  assign out_valid = (w_occ != EMPTY);
  assign full      = (w_occ == FULL);

endmodule

// File: rtl/ones_result_fifo.sv
// Buffers popcount results pulsed on dor/d_out for a show-ahead consumer.
// Running sum/max statistics are built only with ONES_RESULT_STATS_EN defined.
module ones_result_fifo
  import ones_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int CW    = $clog2(W + 1),
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int SUMW  = 16
) (
  input  logic                     clock,
  input  logic                     reset_L,
  input  logic                     dor,
  input  logic [CW-1:0]            d_out,
  input  logic                     rd,
  output logic                     out_valid,
  output logic [CW-1:0]            out_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [SUMW-1:0]          sum,
  output logic [CW-1:0]            max_cnt
);

  logic w_pop;
  logic w_push;
  logic w_drop;
  logic r_overflow;

  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign w_pop  = rd && out_valid;
  assign w_push = dor && (!full || w_pop);
  assign w_drop = dor && !w_push;

  ones_fifo_core #(
    .CW    (CW),
    .DEPTH (DEPTH)
  ) u_core (
    .clock     (clock),
    .reset_L   (reset_L),
    .push      (w_push),
    .pop       (w_pop),
    .wdata     (d_out),
    .out_data  (out_data),
    .level     (level),
    .out_valid (out_valid),
    .full      (full)
  );

  always_ff @(posedge clock) begin
    if (!reset_L)    r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;

`ifdef ONES_RESULT_STATS_EN
  logic [SUMW-1:0] r_sum;
  logic [CW-1:0]   r_max;
  logic [SUMW:0]   w_sum_ext;

  assign w_sum_ext = {1'b0, r_sum} + (SUMW + 1)'(d_out);

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      r_sum <= '0;
      r_max <= '0;
    end else if (w_push) begin
      r_sum <= w_sum_ext[SUMW] ? '1 : w_sum_ext[SUMW-1:0];
      if (d_out > r_max) r_max <= d_out;
    end
  end

  assign sum     = r_sum;
  assign max_cnt = r_max;
`else
  assign sum     = '0;
  assign max_cnt = '0;
`endif

endmodule
